id_stage_pipelined: RTL and testbench
=====================================

Name: id_stage_pipelined

Overview:
Parametrised next-generation instruction decode stage for the MIPS/DLX pipeline. It decodes the instruction, reads the internal register bank and resolves BEQ/BNE/J in ID. It detects load-use and branch-operand hazards and registers all results into an ID/EX pipeline register with bubble insertion. It sits between the IF/ID register and the execute stage, and drives PC selection and stall/flush back to fetch.

Parameters:
DATA_W, 32, data path and register width
PC_W, 10, program counter / branch target width
REG_ADDR_W, 5, register address width (bank depth 2^REG_ADDR_W)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
instruc  input  32  instruction from IF/ID
current_PC  input  PC_W  PC+1 of instruction in ID
hold  input  1  downstream stall: freeze ID/EX register
wb_reg_write  input  1  write-back enable
rw  input  REG_ADDR_W  write-back destination
busw  input  DATA_W  write-back data
mem_reg_write  input  1  EX/MEM instruction writes a register
mem_mem_read  input  1  EX/MEM instruction is a load
mem_rw  input  REG_ADDR_W  EX/MEM destination
mem_alu_result  input  DATA_W  EX/MEM ALU result (branch forwarding)
stall  output  1  hold PC and IF/ID this cycle
if_flush  output  1  squash IF/ID (taken branch or jump)
branch_sel  output  1  PC_sel: take jump_address
jump_address  output  PC_W  branch or jump target
EX_control  output  4  registered {reg_dst, alu_src, alu_op[1:0]}
M_control  output  2  registered {mem_read, mem_write}
WB_control  output  2  registered {reg_write, mem_to_reg}
bus_a  output  DATA_W  registered rs value
bus_b  output  DATA_W  registered rt value
immed_ext  output  DATA_W  registered sign-extended instruc[15:0]
ex_rs, ex_rt, ex_rd  output  REG_ADDR_W each  registered register fields
illegal_op  output  1  registered: unsupported opcode decoded

Behaviour:
- Reset: all ID/EX outputs and illegal_op are 0, i.e. a bubble. All bank registers are cleared to 0. Combinational outputs follow from the zeroed state.
- Opcodes and decode ({EX}/{M}/{WB}):
  - R-type 000000: 1010/00/10
  - LW 100011: 0100/10/11
  - SW 101011: 0100/01/00
  - ADDI 001000: 0100/00/10
  - BEQ 000100, BNE 000101, J 000010: all controls zero
  - Any other opcode: all controls zero (NOP) and illegal_op=1 in the ID/EX slot.
- Register bank:
  - Writes on posedge when wb_reg_write=1 and rw!=0. Register 0 always reads 0.
  - Reads are combinational with write-through: a same-cycle write to rs or rt is seen by ID.
- uses_rt is 1 for R-type, SW, BEQ and BNE.
- Load-use hazard: stall when ID/EX M_control[1]=1, ex_rt!=0, and ex_rt equals rs, or equals rt with uses_rt.
- Branch hazard (BEQ/BNE in ID only) stalls when either source register is nonzero and equals:
  - ex_dest while WB_control[1]=1, where ex_dest = reg_dst ? ex_rd : ex_rt; or
  - mem_rw while mem_reg_write=1 and mem_mem_read=1.
- Branch forwarding: a source matching mem_rw with mem_reg_write=1 and mem_mem_read=0 uses mem_alu_result; otherwise it uses the bank value.
- Branch resolution (all combinational):
  - Taken when (BEQ and a==b) or (BNE and a!=b), using the forwarded operands.
  - Taken target: jump_address = current_PC + instruc[PC_W-1:0], modulo 2^PC_W, wraps silently.
  - J: always taken, jump_address = instruc[PC_W-1:0].
  - branch_sel = taken & !stall & !hold. if_flush = branch_sel.
- ID/EX update on posedge, in priority order:
  1. reset: clear to bubble.
  2. hold: keep all values, with stall/branch_sel still computed.
  3. stall: load a bubble (all controls and illegal_op zero; data fields don't-care, driven 0).
  4. Otherwise: load the decoded values.
- Latency: decode to ID/EX is 1 cycle. Branch decision is 0 cycles. A stall lasts until the hazard clears (load-use is 1 cycle; branch on ALU producer is 1 cycle; branch on load is 2 cycles).
- Reset asserted mid-stall: stall drops the next cycle because the ID/EX bubble clears the hazard sources.

Test Plan:
- Reset → all registered outputs 0 and stall=0. Write r3=0x12345678 via WB, then decode an R-type with rs=3 in the same cycle → bus_a=0x12345678 one cycle later.
- LW r5 ← mem, followed by ADD r6=r5+r1 → stall=1 for exactly 1 cycle, ID/EX controls 0 in the bubble, then ADD loads EX_control=1010.
- BEQ r1,r2 with r1=r2=7, current_PC=0x3F0, immed=0x20 → branch_sel=1, if_flush=1, jump_address=0x010 (wrap).
- BNE r4,r0 with EX/MEM writing r4=9 via ALU (mem_mem_read=0) → forwarded, taken, no stall. Same case with mem_mem_read=1 → stall=1, branch_sel=0.
- hold=1 during stall → ID/EX unchanged. Opcode 111111 → illegal_op=1 and all controls 0 next cycle.
- Write attempt to r0 with busw=0xFFFFFFFF → a read of r0 returns 0.

Source files
------------

// File: rtl/id_stage_pipelined.sv
// Instruction decode stage for a five-stage MIPS/DLX pipeline.
// Decodes the instruction, reads the register bank (write-through), resolves
// BEQ/BNE/J in ID with EX/MEM forwarding, detects load-use and branch-operand
// hazards, and registers the decoded bundle into the ID/EX register.
//
// Flow control with fetch and execute:
//   stall  : ID cannot hand its instruction on this cycle; PC and IF/ID hold,
//            and a bubble is loaded into ID/EX on the next edge.
//   hold   : execute cannot accept; ID/EX keeps its contents. Hazard and
//            branch logic keep evaluating, but no redirect is issued.
//   branch_sel/if_flush : redirect fetch to jump_address and squash IF/ID.
//            Only raised when ID is actually advancing (no stall, no hold).
module id_stage_pipelined #(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 10,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instruc,
  input  logic [PC_W-1:0]       current_PC,
  input  logic                  hold,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] rw,
  input  logic [DATA_W-1:0]     busw,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rw,
  input  logic [DATA_W-1:0]     mem_alu_result,
  output logic                  stall,
  output logic                  if_flush,
  output logic                  branch_sel,
  output logic [PC_W-1:0]       jump_address,
  output logic [3:0]            EX_control,
  output logic [1:0]            M_control,
  output logic [1:0]            WB_control,
  output logic [DATA_W-1:0]     bus_a,
  output logic [DATA_W-1:0]     bus_b,
  output logic [DATA_W-1:0]     immed_ext,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  illegal_op
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ---------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------
  logic [5:0]            w_opcode;
  logic [REG_ADDR_W-1:0] w_rs;
  logic [REG_ADDR_W-1:0] w_rt;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [15:0]           w_imm;
  logic [DATA_W-1:0]     w_imm_ext;

  assign w_opcode  = instruc[31:26];
  assign w_rs      = instruc[21 +: REG_ADDR_W];
  assign w_rt      = instruc[16 +: REG_ADDR_W];
  assign w_rd      = instruc[11 +: REG_ADDR_W];
  assign w_imm     = instruc[15:0];
  assign w_imm_ext = {{(DATA_W-16){w_imm[15]}}, w_imm};

  // ---------------------------------------------------------------------
  // Main decoder
  // ---------------------------------------------------------------------
  logic [3:0] w_ex_ctrl;   // {reg_dst, alu_src, alu_op[1:0]}
  logic [1:0] w_m_ctrl;    // {mem_read, mem_write}
  logic [1:0] w_wb_ctrl;   // {reg_write, mem_to_reg}
  logic       w_illegal;
  logic       w_is_beq;
  logic       w_is_bne;
  logic       w_is_j;
  logic       w_uses_rt;

  // Opcode to control bundle; unknown opcodes become a flagged NOP.
  always_comb begin
    w_ex_ctrl = 4'b0000;
    w_m_ctrl  = 2'b00;
    w_wb_ctrl = 2'b00;
    w_illegal = 1'b0;
    w_is_beq  = 1'b0;
    w_is_bne  = 1'b0;
    w_is_j    = 1'b0;
    w_uses_rt = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        w_ex_ctrl = 4'b1010;
        w_wb_ctrl = 2'b10;
        w_uses_rt = 1'b1;
      end
      OP_LW: begin
        w_ex_ctrl = 4'b0100;
        w_m_ctrl  = 2'b10;
        w_wb_ctrl = 2'b11;
      end
      OP_SW: begin
        w_ex_ctrl = 4'b0100;
        w_m_ctrl  = 2'b01;
        w_uses_rt = 1'b1;
      end
      OP_ADDI: begin
        w_ex_ctrl = 4'b0100;
        w_wb_ctrl = 2'b10;
      end
      OP_BEQ: begin
        w_is_beq  = 1'b1;
        w_uses_rt = 1'b1;
      end
      OP_BNE: begin
        w_is_bne  = 1'b1;
        w_uses_rt = 1'b1;
      end
      OP_J: begin
        w_is_j = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] r_bank [NUM_REGS];
  logic [DATA_W-1:0] w_reg_a;
  logic [DATA_W-1:0] w_reg_b;

  // Write-back port; register 0 is never written so it stays hardwired to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_bank[i] <= '0;
      end
    end else if (wb_reg_write && (rw != '0)) begin
      r_bank[rw] <= busw;
    end
  end

  // Read port A with write-through so a same-cycle write-back is visible.
  always_comb begin
    w_reg_a = r_bank[w_rs];
    if (w_rs == '0) begin
      w_reg_a = '0;
    end else if (wb_reg_write && (rw == w_rs)) begin
      w_reg_a = busw;
    end
  end

  // Read port B with write-through so a same-cycle write-back is visible.
  always_comb begin
    w_reg_b = r_bank[w_rt];
    if (w_rt == '0) begin
      w_reg_b = '0;
    end else if (wb_reg_write && (rw == w_rt)) begin
      w_reg_b = busw;
    end
  end

  // ---------------------------------------------------------------------
  // ID/EX register state
  // ---------------------------------------------------------------------
  logic [3:0]            r_ex_control;
  logic [1:0]            r_m_control;
  logic [1:0]            r_wb_control;
  logic [DATA_W-1:0]     r_bus_a;
  logic [DATA_W-1:0]     r_bus_b;
  logic [DATA_W-1:0]     r_immed_ext;
  logic [REG_ADDR_W-1:0] r_ex_rs;
  logic [REG_ADDR_W-1:0] r_ex_rt;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  r_illegal_op;

  // ---------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------
  logic                  w_is_branch;
  logic [REG_ADDR_W-1:0] w_ex_dest;
  logic                  w_load_use;
  logic                  w_br_haz_rs;
  logic                  w_br_haz_rt;
  logic                  w_branch_hazard;
  logic                  w_stall;

  assign w_is_branch = w_is_beq | w_is_bne;

  // Destination of the instruction now sitting in ID/EX (rd for R-type).
  assign w_ex_dest = r_ex_control[3] ? r_ex_rd : r_ex_rt;

  // Load in ID/EX whose target is consumed by the instruction in ID.
  assign w_load_use = r_m_control[1] && (r_ex_rt != '0) &&
                      ((r_ex_rt == w_rs) || (w_uses_rt && (r_ex_rt == w_rt)));

  // A branch source is not yet available: still in EX, or a load in MEM.
  assign w_br_haz_rs = (w_rs != '0) &&
                       ((r_wb_control[1] && (w_ex_dest == w_rs)) ||
                        (mem_reg_write && mem_mem_read && (mem_rw == w_rs)));
  assign w_br_haz_rt = (w_rt != '0) &&
                       ((r_wb_control[1] && (w_ex_dest == w_rt)) ||
                        (mem_reg_write && mem_mem_read && (mem_rw == w_rt)));
  assign w_branch_hazard = w_is_branch && (w_br_haz_rs || w_br_haz_rt);

  assign w_stall = w_load_use | w_branch_hazard;

  // ---------------------------------------------------------------------
  // Branch resolution with EX/MEM ALU forwarding
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] w_br_a;
  logic [DATA_W-1:0] w_br_b;
  logic              w_taken;
  logic [PC_W-1:0]   w_branch_target;

  // Forward the EX/MEM ALU result to the comparator; register 0 is never
  // forwarded because its architectural value is always 0.
  always_comb begin
    w_br_a = w_reg_a;
    w_br_b = w_reg_b;
    if (mem_reg_write && !mem_mem_read && (mem_rw != '0) && (mem_rw == w_rs)) begin
      w_br_a = mem_alu_result;
    end
    if (mem_reg_write && !mem_mem_read && (mem_rw != '0) && (mem_rw == w_rt)) begin
      w_br_b = mem_alu_result;
    end
  end

  // PC-relative target wraps modulo 2^PC_W.
  assign w_branch_target = current_PC + instruc[PC_W-1:0];

  assign w_taken = w_is_j ||
                   (w_is_beq && (w_br_a == w_br_b)) ||
                   (w_is_bne && (w_br_a != w_br_b));

  assign jump_address = w_is_j ? instruc[PC_W-1:0] : w_branch_target;
  assign branch_sel   = w_taken & ~w_stall & ~hold;
  assign if_flush     = branch_sel;
  assign stall        = w_stall;

  // ---------------------------------------------------------------------
  // ID/EX pipeline register
  // ---------------------------------------------------------------------

  // Priority: reset bubble, hold keeps, stall inserts bubble, else advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_control <= '0;
      r_m_control  <= '0;
      r_wb_control <= '0;
      r_bus_a      <= '0;
      r_bus_b      <= '0;
      r_immed_ext  <= '0;
      r_ex_rs      <= '0;
      r_ex_rt      <= '0;
      r_ex_rd      <= '0;
      r_illegal_op <= 1'b0;
    end else if (hold) begin
      r_ex_control <= r_ex_control;
      r_m_control  <= r_m_control;
      r_wb_control <= r_wb_control;
      r_bus_a      <= r_bus_a;
      r_bus_b      <= r_bus_b;
      r_immed_ext  <= r_immed_ext;
      r_ex_rs      <= r_ex_rs;
      r_ex_rt      <= r_ex_rt;
      r_ex_rd      <= r_ex_rd;
      r_illegal_op <= r_illegal_op;
    end else if (w_stall) begin
      r_ex_control <= '0;
      r_m_control  <= '0;
      r_wb_control <= '0;
      r_bus_a      <= '0;
      r_bus_b      <= '0;
      r_immed_ext  <= '0;
      r_ex_rs      <= '0;
      r_ex_rt      <= '0;
      r_ex_rd      <= '0;
      r_illegal_op <= 1'b0;
    end else begin
      r_ex_control <= w_ex_ctrl;
      r_m_control  <= w_m_ctrl;
      r_wb_control <= w_wb_ctrl;
      r_bus_a      <= w_reg_a;
      r_bus_b      <= w_reg_b;
      r_immed_ext  <= w_imm_ext;
      r_ex_rs      <= w_rs;
      r_ex_rt      <= w_rt;
      r_ex_rd      <= w_rd;
      r_illegal_op <= w_illegal;
    end
  end

  assign EX_control = r_ex_control;
  assign M_control  = r_m_control;
  assign WB_control = r_wb_control;
  assign bus_a      = r_bus_a;
  assign bus_b      = r_bus_b;
  assign immed_ext  = r_immed_ext;
  assign ex_rs      = r_ex_rs;
  assign ex_rt      = r_ex_rt;
  assign ex_rd      = r_ex_rd;
  assign illegal_op = r_illegal_op;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined: decode, register bank write-through,
// load-use and branch hazards, forwarding, hold, and illegal opcodes.
module tb_id_stage_pipelined;

  localparam int DATA_W     = 32;
  localparam int PC_W       = 10;
  localparam int REG_ADDR_W = 5;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  logic                  clk;
  logic                  reset;
  logic [31:0]           instruc;
  logic [PC_W-1:0]       current_PC;
  logic                  hold;
  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] rw;
  logic [DATA_W-1:0]     busw;
  logic                  mem_reg_write;
  logic                  mem_mem_read;
  logic [REG_ADDR_W-1:0] mem_rw;
  logic [DATA_W-1:0]     mem_alu_result;
  logic                  stall;
  logic                  if_flush;
  logic                  branch_sel;
  logic [PC_W-1:0]       jump_address;
  logic [3:0]            EX_control;
  logic [1:0]            M_control;
  logic [1:0]            WB_control;
  logic [DATA_W-1:0]     bus_a;
  logic [DATA_W-1:0]     bus_b;
  logic [DATA_W-1:0]     immed_ext;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  illegal_op;

  int n_cmp;
  int n_fail;

  id_stage_pipelined #(
    .DATA_W(DATA_W), .PC_W(PC_W), .REG_ADDR_W(REG_ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .instruc(instruc), .current_PC(current_PC),
    .hold(hold), .wb_reg_write(wb_reg_write), .rw(rw), .busw(busw),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_rw(mem_rw), .mem_alu_result(mem_alu_result),
    .stall(stall), .if_flush(if_flush), .branch_sel(branch_sel),
    .jump_address(jump_address), .EX_control(EX_control),
    .M_control(M_control), .WB_control(WB_control), .bus_a(bus_a),
    .bus_b(bus_b), .immed_ext(immed_ext), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .illegal_op(illegal_op)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // ---------------- driver tasks ----------------
  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    instruc        = 32'h0;
    current_PC     = '0;
    hold           = 1'b0;
    wb_reg_write   = 1'b0;
    rw             = '0;
    busw           = '0;
    mem_reg_write  = 1'b0;
    mem_mem_read   = 1'b0;
    mem_rw         = '0;
    mem_alu_result = '0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    instruc      = 32'h0;
    wb_reg_write = 1'b1;
    rw           = a;
    busw         = d;
    tick();
    wb_reg_write = 1'b0;
    rw           = '0;
    busw         = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    tick();
    tick();
    if (EX_control !== 4'b0) begin $display("FAIL rst_ex: got %b expected 0000", EX_control); n_fail++; end n_cmp++;
    if (M_control !== 2'b0) begin $display("FAIL rst_m: got %b expected 00", M_control); n_fail++; end n_cmp++;
    if (WB_control !== 2'b0) begin $display("FAIL rst_wb: got %b expected 00", WB_control); n_fail++; end n_cmp++;
    if ({bus_a, bus_b, immed_ext} !== 96'h0) begin $display("FAIL rst_data: got %h %h %h expected zeros", bus_a, bus_b, immed_ext); n_fail++; end n_cmp++;
    if ({ex_rs, ex_rt, ex_rd, illegal_op} !== 16'h0) begin $display("FAIL rst_fields: got %h %h %h %b expected zeros", ex_rs, ex_rt, ex_rd, illegal_op); n_fail++; end n_cmp++;
    if (stall !== 1'b0) begin $display("FAIL rst_stall: got %b expected 0", stall); n_fail++; end n_cmp++;
    reset = 1'b0;
  endtask

  task automatic test_write_through();
    instruc      = enc_r(5'd3, 5'd0, 5'd7);
    wb_reg_write = 1'b1;
    rw           = 5'd3;
    busw         = 32'h12345678;
    tick();
    wb_reg_write = 1'b0;
    rw           = '0;
    if (bus_a !== 32'h12345678) begin $display("FAIL wt_bus_a: got %h expected 12345678", bus_a); n_fail++; end n_cmp++;
    if (bus_b !== 32'h0) begin $display("FAIL wt_bus_b: got %h expected 00000000", bus_b); n_fail++; end n_cmp++;
    if (EX_control !== 4'b1010) begin $display("FAIL wt_ex: got %b expected 1010", EX_control); n_fail++; end n_cmp++;
    if ({M_control, WB_control} !== 4'b0010) begin $display("FAIL wt_m_wb: got %b expected 0010", {M_control, WB_control}); n_fail++; end n_cmp++;
    if ({ex_rs, ex_rt, ex_rd} !== {5'd3, 5'd0, 5'd7}) begin $display("FAIL wt_fields: got %0d %0d %0d expected 3 0 7", ex_rs, ex_rt, ex_rd); n_fail++; end n_cmp++;
    instruc = enc_r(5'd3, 5'd3, 5'd8);
    tick();
    if ({bus_a, bus_b} !== {32'h12345678, 32'h12345678}) begin $display("FAIL bank_hold: got %h %h expected 12345678 12345678", bus_a, bus_b); n_fail++; end n_cmp++;
  endtask

  task automatic test_r0_write();
    instruc      = enc_r(5'd0, 5'd0, 5'd1);
    wb_reg_write = 1'b1;
    rw           = 5'd0;
    busw         = 32'hFFFFFFFF;
    tick();
    wb_reg_write = 1'b0;
    busw         = '0;
    if ({bus_a, bus_b} !== 64'h0) begin $display("FAIL r0_wt: got %h %h expected 0 0", bus_a, bus_b); n_fail++; end n_cmp++;
    tick();
    if (bus_a !== 32'h0) begin $display("FAIL r0_bank: got %h expected 00000000", bus_a); n_fail++; end n_cmp++;
  endtask

  task automatic test_load_use();
    write_reg(5'd1, 32'h11);
    instruc = enc_i(OP_LW, 5'd1, 5'd5, 16'h8004);
    #1;
    if (stall !== 1'b0) begin $display("FAIL lu_pre_stall: got %b expected 0", stall); n_fail++; end n_cmp++;
    tick();
    if ({EX_control, M_control, WB_control} !== 8'b0100_10_11) begin $display("FAIL lw_ctrl: got %b expected 01001011", {EX_control, M_control, WB_control}); n_fail++; end n_cmp++;
    if (immed_ext !== 32'hFFFF8004) begin $display("FAIL lw_immed: got %h expected ffff8004", immed_ext); n_fail++; end n_cmp++;
    if ({bus_a, ex_rt} !== {32'h11, 5'd5}) begin $display("FAIL lw_data: got %h %0d expected 11 5", bus_a, ex_rt); n_fail++; end n_cmp++;
    instruc = enc_r(5'd5, 5'd1, 5'd6);
    #1;
    if ({stall, branch_sel} !== 2'b10) begin $display("FAIL lu_stall: got %b expected 10", {stall, branch_sel}); n_fail++; end n_cmp++;
    tick();
    if ({EX_control, M_control, WB_control, illegal_op} !== 9'b0) begin $display("FAIL lu_bubble: got %b expected 000000000", {EX_control, M_control, WB_control, illegal_op}); n_fail++; end n_cmp++;
    if (stall !== 1'b0) begin $display("FAIL lu_one_cycle: got %b expected 0", stall); n_fail++; end n_cmp++;
    tick();
    if ({EX_control, WB_control} !== 6'b1010_10) begin $display("FAIL lu_add: got %b expected 101010", {EX_control, WB_control}); n_fail++; end n_cmp++;
    if ({ex_rs, ex_rd} !== {5'd5, 5'd6}) begin $display("FAIL lu_add_fields: got %0d %0d expected 5 6", ex_rs, ex_rd); n_fail++; end n_cmp++;
    // rt of ADDI is a destination, so it must not trigger a load-use stall
    instruc = enc_i(OP_LW, 5'd1, 5'd5, 16'h0);
    tick();
    instruc = enc_i(OP_ADDI, 5'd1, 5'd5, 16'h1);
    #1;
    if (stall !== 1'b0) begin $display("FAIL lu_addi_rt: got %b expected 0", stall); n_fail++; end n_cmp++;
    instruc = enc_i(OP_SW, 5'd1, 5'd5, 16'h0);
    #1;
    if (stall !== 1'b1) begin $display("FAIL lu_sw_rt: got %b expected 1", stall); n_fail++; end n_cmp++;
    tick();
    instruc = 32'h0;
    tick();
  endtask

  task automatic test_hold();
    instruc = enc_i(OP_LW, 5'd1, 5'd5, 16'h0);
    tick();
    instruc = enc_r(5'd5, 5'd1, 5'd6);
    hold    = 1'b1;
    #1;
    if ({stall, branch_sel} !== 2'b10) begin $display("FAIL hold_stall: got %b expected 10", {stall, branch_sel}); n_fail++; end n_cmp++;
    tick();
    tick();
    if ({EX_control, M_control, WB_control, ex_rt} !== {8'b0100_10_11, 5'd5}) begin $display("FAIL hold_keep: got %b %0d expected 01001011 5", {EX_control, M_control, WB_control}, ex_rt); n_fail++; end n_cmp++;
    hold = 1'b0;
    tick();
    if (M_control !== 2'b00) begin $display("FAIL hold_release: got %b expected 00", M_control); n_fail++; end n_cmp++;
    instruc = 32'h0;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    instruc = enc_i(OP_LW, 5'd1, 5'd5, 16'h0);
    tick();
    instruc = enc_r(5'd5, 5'd1, 5'd6);
    #1;
    if (stall !== 1'b1) begin $display("FAIL rms_pre: got %b expected 1", stall); n_fail++; end n_cmp++;
    reset = 1'b1;
    tick();
    if ({stall, M_control} !== 3'b000) begin $display("FAIL rms_drop: got %b expected 000", {stall, M_control}); n_fail++; end n_cmp++;
    reset   = 1'b0;
    instruc = enc_r(5'd1, 5'd0, 5'd2);
    tick();
    if (bus_a !== 32'h0) begin $display("FAIL rms_bank_clear: got %h expected 00000000", bus_a); n_fail++; end n_cmp++;
  endtask

  task automatic test_branch();
    write_reg(5'd1, 32'h7);
    write_reg(5'd2, 32'h7);
    instruc    = enc_i(OP_BEQ, 5'd1, 5'd2, 16'h0020);
    current_PC = 10'h3F0;
    #1;
    if ({stall, branch_sel, if_flush} !== 3'b011) begin $display("FAIL beq_taken: got %b expected 011", {stall, branch_sel, if_flush}); n_fail++; end n_cmp++;
    if (jump_address !== 10'h010) begin $display("FAIL beq_wrap: got %h expected 010", jump_address); n_fail++; end n_cmp++;
    instruc = enc_i(OP_BEQ, 5'd1, 5'd3, 16'h0020);
    #1;
    if ({branch_sel, if_flush} !== 2'b00) begin $display("FAIL beq_not_taken: got %b expected 00", {branch_sel, if_flush}); n_fail++; end n_cmp++;
    instruc = enc_i(OP_BNE, 5'd1, 5'd3, 16'h0020);
    #1;
    if ({branch_sel, jump_address} !== {1'b1, 10'h010}) begin $display("FAIL bne_taken: got %b %h expected 1 010", branch_sel, jump_address); n_fail++; end n_cmp++;
    tick();
    if ({EX_control, M_control, WB_control, illegal_op} !== 9'b0) begin $display("FAIL bne_ctrl: got %b expected 000000000", {EX_control, M_control, WB_control, illegal_op}); n_fail++; end n_cmp++;
  endtask

  task automatic test_jump();
    instruc    = {6'b000010, 16'h0, 10'h2A5};
    current_PC = 10'h100;
    #1;
    if ({branch_sel, if_flush, jump_address} !== {2'b11, 10'h2A5}) begin $display("FAIL j_taken: got %b %b %h expected 1 1 2a5", branch_sel, if_flush, jump_address); n_fail++; end n_cmp++;
    hold = 1'b1;
    #1;
    if ({branch_sel, if_flush} !== 2'b00) begin $display("FAIL j_hold: got %b expected 00", {branch_sel, if_flush}); n_fail++; end n_cmp++;
    hold    = 1'b0;
    instruc = 32'h0;
    tick();
  endtask

  task automatic test_forward();
    instruc        = enc_i(OP_BNE, 5'd4, 5'd0, 16'h0005);
    current_PC     = 10'h010;
    mem_reg_write  = 1'b1;
    mem_mem_read   = 1'b0;
    mem_rw         = 5'd4;
    mem_alu_result = 32'h9;
    #1;
    if ({stall, branch_sel, jump_address} !== {2'b01, 10'h015}) begin $display("FAIL fwd_alu: got %b %b %h expected 0 1 015", stall, branch_sel, jump_address); n_fail++; end n_cmp++;
    mem_mem_read = 1'b1;
    #1;
    if ({stall, branch_sel, if_flush} !== 3'b100) begin $display("FAIL fwd_load_stall: got %b expected 100", {stall, branch_sel, if_flush}); n_fail++; end n_cmp++;
    mem_reg_write = 1'b0;
    mem_mem_read  = 1'b0;
    #1;
    if ({stall, branch_sel} !== 2'b00) begin $display("FAIL fwd_none: got %b expected 00", {stall, branch_sel}); n_fail++; end n_cmp++;
    set_idle();
    tick();
  endtask

  task automatic test_branch_hazard();
    instruc = enc_r(5'd1, 5'd2, 5'd4);
    tick();
    instruc    = enc_i(OP_BNE, 5'd4, 5'd0, 16'h0005);
    current_PC = 10'h010;
    #1;
    if ({stall, branch_sel} !== 2'b10) begin $display("FAIL bh_ex_stall: got %b expected 10", {stall, branch_sel}); n_fail++; end n_cmp++;
    tick();
    mem_reg_write  = 1'b1;
    mem_rw         = 5'd4;
    mem_alu_result = 32'hE;
    #1;
    if ({stall, branch_sel} !== 2'b01) begin $display("FAIL bh_resolved: got %b expected 01", {stall, branch_sel}); n_fail++; end n_cmp++;
    set_idle();
    tick();
  endtask

  task automatic test_illegal_and_decode();
    instruc = {6'b111111, 26'h0};
    tick();
    if ({illegal_op, EX_control, M_control, WB_control} !== 9'b1_0000_00_00) begin $display("FAIL illegal: got %b expected 100000000", {illegal_op, EX_control, M_control, WB_control}); n_fail++; end n_cmp++;
    instruc = enc_i(OP_ADDI, 5'd1, 5'd7, 16'hFFFE);
    tick();
    if ({illegal_op, EX_control, M_control, WB_control} !== 9'b0_0100_00_10) begin $display("FAIL addi_ctrl: got %b expected 001000010", {illegal_op, EX_control, M_control, WB_control}); n_fail++; end n_cmp++;
    if ({immed_ext, ex_rt} !== {32'hFFFFFFFE, 5'd7}) begin $display("FAIL addi_immed: got %h %0d expected fffffffe 7", immed_ext, ex_rt); n_fail++; end n_cmp++;
    instruc = enc_i(OP_SW, 5'd1, 5'd2, 16'h0004);
    tick();
    if ({EX_control, M_control, WB_control} !== 8'b0100_01_00) begin $display("FAIL sw_ctrl: got %b expected 01000100", {EX_control, M_control, WB_control}); n_fail++; end n_cmp++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    set_idle();
    test_reset();
    test_write_through();
    test_r0_write();
    test_load_use();
    test_hold();
    test_reset_mid_stall();
    test_branch();
    test_jump();
    test_forward();
    test_branch_hazard();
    test_illegal_and_decode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
